// File: rtl/vu_lane_fu_share_if.sv
// Coprocessor request/response bundle for one shared lane functional unit.
// Both channels transfer on a cycle where the valid and ready of that channel are both high.
interface vu_lane_fu_share_if #(
    parameter int FNW = 11,
    parameter int XW  = 64,
    parameter int EW  = 5
);
    logic           cp_val;
    logic           cp_rdy;
    logic [FNW-1:0] cp_fn;
    logic [XW-1:0]  cp_in0;
    logic [XW-1:0]  cp_in1;
    logic [XW-1:0]  cp_in2;

    logic           cp_resp_val;
    logic           cp_resp_rdy;
    logic [XW-1:0]  cp_resp_bits;
    logic [EW-1:0]  cp_resp_exc;

    modport master (
        output cp_val, cp_fn, cp_in0, cp_in1, cp_in2, cp_resp_rdy,
        input  cp_rdy, cp_resp_val, cp_resp_bits, cp_resp_exc
    );

    modport slave (
        input  cp_val, cp_fn, cp_in0, cp_in1, cp_in2, cp_resp_rdy,
        output cp_rdy, cp_resp_val, cp_resp_bits, cp_resp_exc
    );
endinterface

// File: rtl/vu_lane_fu_share.sv
// Shares one fixed-latency lane FU between the vector issue path and the coprocessor.
// Vector ops always win; cp results are parked in a credit-limited response FIFO.
module vu_lane_fu_share #(
    parameter int W      = 65,
    parameter int XW     = 64,
    parameter int FNW    = 11,
    parameter int EW     = 5,
    parameter int LAT    = 4,
    parameter int CPQ    = 2,
    parameter int STARVE = 8
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           vu_val,
    input  logic [FNW-1:0] vu_fn,
    input  logic [W-1:0]   vu_in0,
    input  logic [W-1:0]   vu_in1,
    input  logic [W-1:0]   vu_in2,

    vu_lane_fu_share_if.slave cp,

    output logic           fu_val,
    output logic [FNW-1:0] fu_fn,
    output logic [W-1:0]   fu_in0,
    output logic [W-1:0]   fu_in1,
    output logic [W-1:0]   fu_in2,
    input  logic [W-1:0]   fu_out,
    input  logic [EW-1:0]  fu_exc,

    output logic           wb_val,
    output logic [W-1:0]   wb_data,
    output logic           cp_starve
);

    localparam int PW = (CPQ > 1) ? $clog2(CPQ) : 1;
    localparam int CW = $clog2(CPQ + 1);
    localparam int SW = $clog2(STARVE + 1);

    // ---------------- issue ----------------
    logic [CW-1:0] credit;
    logic          cp_fire;

    assign cp.cp_rdy = ~vu_val & (credit < CW'(CPQ));
    assign cp_fire   = cp.cp_val & cp.cp_rdy;
    assign fu_val    = vu_val | cp_fire;

    always_comb begin
        if (vu_val) begin
            fu_fn  = vu_fn;
            fu_in0 = vu_in0;
            fu_in1 = vu_in1;
            fu_in2 = vu_in2;
        end else begin
            fu_fn  = cp.cp_fn;
            fu_in0 = W'(cp.cp_in0);
            fu_in1 = W'(cp.cp_in1);
            fu_in2 = W'(cp.cp_in2);
        end
    end

    // ---------------- owner pipe ----------------
    // Entry LAT-1 describes the op whose result is on fu_out this cycle.
    logic [LAT-1:0] own_v;
    logic [LAT-1:0] own_cp;
    logic           tail_v;
    logic           tail_cp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_v  <= '0;
            own_cp <= '0;
        end else begin
            own_v[0]  <= fu_val;
            own_cp[0] <= cp_fire;
            for (int i = 1; i < LAT; i++) begin
                own_v[i]  <= own_v[i-1];
                own_cp[i] <= own_cp[i-1];
            end
        end
    end

    assign tail_v  = own_v[LAT-1];
    assign tail_cp = own_cp[LAT-1];

    assign wb_val  = tail_v & ~tail_cp;
    assign wb_data = fu_out;

    // ---------------- cp response FIFO ----------------
    logic [XW-1:0] q_bits [CPQ];
    logic [EW-1:0] q_exc  [CPQ];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CPQ - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push = tail_v & tail_cp;
    assign pop  = cp.cp_resp_val & cp.cp_resp_rdy;

    assign cp.cp_resp_val  = (count != '0);
    assign cp.cp_resp_bits = q_bits[rd_ptr];
    assign cp.cp_resp_exc  = q_exc[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CPQ; i++) begin
                q_bits[i] <= '0;
                q_exc[i]  <= '0;
            end
        end else begin
            if (push) begin
                q_bits[wr_ptr] <= fu_out[XW-1:0];
                q_exc[wr_ptr]  <= fu_exc;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- credits ----------------
    // A credit is held from issue until the response is popped, so the FIFO never overflows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit <= '0;
        end else begin
            case ({cp_fire, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // ---------------- starvation ----------------
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    // Only cycles lost to a vector op count; credit-limited stalls hold the count.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!cp.cp_val || cp_fire) begin
            starve_nxt = '0;
        end else if (vu_val && (starve_cnt != SW'(STARVE))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            cp_starve  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            cp_starve  <= (starve_nxt == SW'(STARVE));
        end
    end

    // ---------------- invariants ----------------
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == CW'(CPQ))));
    a_credit_range: assert property (@(posedge clk) disable iff (!reset)
        credit <= CW'(CPQ));
    a_count_le_credit: assert property (@(posedge clk) disable iff (!reset)
        count <= credit);

endmodule

// File: tb/tb_vu_lane_fu_share.sv
// Bench for vu_lane_fu_share: reset-time vector table, directed sequences and random
// traffic, all checked against an op-queue model of the arbiter.
module tb_vu_lane_fu_share;
    localparam int W      = 65;
    localparam int XW     = 64;
    localparam int FNW    = 11;
    localparam int EW     = 5;
    localparam int LAT    = 4;
    localparam int CPQ    = 2;
    localparam int STARVE = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic           vu_val;
    logic [FNW-1:0] vu_fn;
    logic [W-1:0]   vu_in0, vu_in1, vu_in2;
    logic           fu_val;
    logic [FNW-1:0] fu_fn;
    logic [W-1:0]   fu_in0, fu_in1, fu_in2;
    logic [W-1:0]   fu_out;
    logic [EW-1:0]  fu_exc;
    logic           wb_val;
    logic [W-1:0]   wb_data;
    logic           cp_starve;

    vu_lane_fu_share_if #(.FNW(FNW), .XW(XW), .EW(EW)) cp ();

    vu_lane_fu_share #(
        .W(W), .XW(XW), .FNW(FNW), .EW(EW), .LAT(LAT), .CPQ(CPQ), .STARVE(STARVE)
    ) dut (
        .clk(clk), .reset(reset),
        .vu_val(vu_val), .vu_fn(vu_fn), .vu_in0(vu_in0), .vu_in1(vu_in1), .vu_in2(vu_in2),
        .cp(cp),
        .fu_val(fu_val), .fu_fn(fu_fn), .fu_in0(fu_in0), .fu_in1(fu_in1), .fu_in2(fu_in2),
        .fu_out(fu_out), .fu_exc(fu_exc),
        .wb_val(wb_val), .wb_data(wb_data), .cp_starve(cp_starve)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: every issued op is remembered with the cycle its result appears on fu_out.
    typedef struct {
        int due;
        bit is_cp;
    } op_t;

    op_t                 ops_q[$];
    logic [XW+EW-1:0]    exp_q[$];
    int                  credit_m;
    int                  run_m;
    int                  cyc;
    bit                  obs_fire, obs_pop, obs_wb;

    task automatic model_clear();
        ops_q.delete();
        exp_q.delete();
        credit_m = 0;
        run_m    = 0;
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, return #1 after the rising edge.
    task automatic cycle();
        bit           rdy_e, fire, pop, due_v, due_cp;
        logic [W-1:0] e0, e1, e2;
        logic [FNW-1:0] efn;
        @(negedge clk);
        rdy_e = !vu_val && (credit_m < CPQ);
        fire  = cp.cp_val && rdy_e;
        chk("cp_rdy", cp.cp_rdy, rdy_e);
        chk("fu_val", fu_val, vu_val || fire);
        efn = vu_val ? vu_fn  : cp.cp_fn;
        e0  = vu_val ? vu_in0 : W'(cp.cp_in0);
        e1  = vu_val ? vu_in1 : W'(cp.cp_in1);
        e2  = vu_val ? vu_in2 : W'(cp.cp_in2);
        chk("fu_fn", fu_fn, efn);
        chk("fu_in0", fu_in0, e0);
        chk("fu_in1", fu_in1, e1);
        chk("fu_in2", fu_in2, e2);
        due_v  = (ops_q.size() != 0) && (ops_q[0].due == cyc);
        due_cp = due_v && ops_q[0].is_cp;
        chk("wb_val", wb_val, due_v && !due_cp);
        if (due_v && !due_cp) chk("wb_data", wb_data, fu_out);
        chk("cp_resp_val", cp.cp_resp_val, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("cp_resp", {cp.cp_resp_bits, cp.cp_resp_exc}, exp_q[0]);
        chk("cp_starve", cp_starve, run_m >= STARVE);
        pop = (exp_q.size() != 0) && cp.cp_resp_rdy;
        if (pop) void'(exp_q.pop_front());
        if (due_v) begin
            if (due_cp) exp_q.push_back({fu_out[XW-1:0], fu_exc});
            void'(ops_q.pop_front());
        end
        credit_m = credit_m + (fire ? 1 : 0) - (pop ? 1 : 0);
        if (!cp.cp_val || fire) run_m = 0;
        else if (vu_val && run_m < STARVE) run_m++;
        if (vu_val || fire) ops_q.push_back('{cyc + LAT, !vu_val});
        obs_fire = fire;
        obs_pop  = pop;
        obs_wb   = due_v && !due_cp;
        cyc++;
        @(posedge clk);
        #1;
        fu_out = rnd_w();
        fu_exc = EW'($urandom);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        vu_val         = 1'b0;
        cp.cp_val      = 1'b0;
        cp.cp_resp_rdy = 1'b0;
    endtask

    task automatic rand_operands();
        vu_fn     = FNW'($urandom);
        vu_in0    = rnd_w();
        vu_in1    = rnd_w();
        vu_in2    = rnd_w();
        cp.cp_fn  = FNW'($urandom);
        cp.cp_in0 = {$urandom, $urandom};
        cp.cp_in1 = {$urandom, $urandom};
        cp.cp_in2 = {$urandom, $urandom};
    endtask

    task automatic drain();
        idle_inputs();
        cp.cp_resp_rdy = 1'b1;
        for (int i = 0; i < LAT + CPQ + 3; i++) cycle();
        cp.cp_resp_rdy = 1'b0;
    endtask

    // ---------------- reset-time vector table ----------------
    typedef struct {
        logic           vu_val;
        logic           cp_val;
        logic [W-1:0]   v0;
        logic [XW-1:0]  c0;
        logic           e_fu_val;
        logic           e_rdy;
        logic           e_sel_vu;
        logic [W-1:0]   e_in0;
    } tv_t;

    tv_t tv[6];

    initial begin
        int cnt, first_wb, last_wb, start;

        idle_inputs();
        rand_operands();
        fu_out = '0;
        fu_exc = '0;
        cyc    = 0;
        model_clear();

        tv[0] = '{1'b0, 1'b0, 65'h1_2345_6789_ABCD_EF01, 64'h0000_0000_0000_0055, 1'b0, 1'b1, 1'b0, 65'h0_0000_0000_0000_0055};
        tv[1] = '{1'b1, 1'b0, 65'h1_2345_6789_ABCD_EF01, 64'h0000_0000_0000_0055, 1'b1, 1'b0, 1'b1, 65'h1_2345_6789_ABCD_EF01};
        tv[2] = '{1'b0, 1'b1, 65'h0_0000_0000_0000_0007, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b0, 65'h0_8000_0000_0000_0001};
        tv[3] = '{1'b1, 1'b1, 65'h0_0000_0000_0000_0007, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 65'h0_0000_0000_0000_0007};
        tv[4] = '{1'b0, 1'b1, 65'h1_0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFF};
        tv[5] = '{1'b1, 1'b0, 65'h1_0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 65'h1_0000_0000_0000_0000};

        #1;
        for (int i = 0; i < 6; i++) begin
            vu_val    = tv[i].vu_val;
            cp.cp_val = tv[i].cp_val;
            vu_in0    = tv[i].v0;
            cp.cp_in0 = tv[i].c0;
            vu_fn     = 11'h123;
            cp.cp_fn  = 11'h456;
            #1;
            chk("tv_fu_val", fu_val, tv[i].e_fu_val);
            chk("tv_cp_rdy", cp.cp_rdy, tv[i].e_rdy);
            chk("tv_fu_fn", fu_fn, tv[i].e_sel_vu ? 11'h123 : 11'h456);
            chk("tv_fu_in0", fu_in0, tv[i].e_in0);
            chk("tv_wb_val", wb_val, 1'b0);
            chk("tv_resp_val", cp.cp_resp_val, 1'b0);
            chk("tv_starve", cp_starve, 1'b0);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) cycle();

        // Vector burst: 8 ops, results on cycles 4..11 relative to the first issue.
        start = cyc; cnt = 0; first_wb = -1; last_wb = -1;
        for (int i = 0; i < 8 + LAT + 2; i++) begin
            vu_val = (i < 8);
            rand_operands();
            cycle();
            if (obs_wb) begin
                cnt++;
                if (first_wb < 0) first_wb = cyc - 1 - start;
                last_wb = cyc - 1 - start;
            end
        end
        chk("burst_wb_count", cnt, 8);
        chk("burst_first_wb", first_wb, LAT);
        chk("burst_last_wb", last_wb, LAT + 7);

        // Single cp op with a known FU result.
        idle_inputs();
        cp.cp_val = 1'b1;
        cp.cp_in0 = 64'h1;
        #1;
        chk("cp_zext_in0", fu_in0, 65'h0_0000_0000_0000_0001);
        cycle();
        chk("single_fire", obs_fire, 1'b1);
        cp.cp_val = 1'b0;
        for (int i = 1; i < LAT; i++) cycle();
        fu_out = 65'h2A;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("single_resp_val", cp.cp_resp_val, 1'b1);
            chk("single_resp_bits", cp.cp_resp_bits, 64'h2A);
            cycle();
        end
        cp.cp_resp_rdy = 1'b1;
        cycle();
        chk("single_pop", obs_pop, 1'b1);
        cp.cp_resp_rdy = 1'b0;
        chk("single_empty", cp.cp_resp_val, 1'b0);
        drain();

        // Credit stall: only CPQ ops issue while nothing is popped.
        cnt = 0;
        cp.cp_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_operands();
            cycle();
            if (obs_fire) cnt++;
        end
        chk("stall_fires", cnt, CPQ);
        chk("stall_rdy_low", cp.cp_rdy, 1'b0);
        cp.cp_resp_rdy = 1'b1;
        cycle();
        chk("stall_pop", obs_pop, 1'b1);
        cp.cp_resp_rdy = 1'b0;
        chk("stall_rdy_back", cp.cp_rdy, 1'b1);
        cycle();
        chk("stall_refire", obs_fire, 1'b1);
        drain();

        // Priority: 3 vector cycles block the cp op, which fires on the 4th.
        for (int i = 0; i < 3; i++) begin
            vu_val = 1'b1; cp.cp_val = 1'b1;
            rand_operands();
            #1;
            chk("prio_rdy_low", cp.cp_rdy, 1'b0);
            cycle();
        end
        vu_val = 1'b0;
        cycle();
        chk("prio_fire", obs_fire, 1'b1);
        drain();

        // Starvation: STARVE blocked cycles raise cp_starve, one fire clears it.
        for (int i = 0; i < STARVE; i++) begin
            vu_val = 1'b1; cp.cp_val = 1'b1;
            rand_operands();
            cycle();
            chk("starve_rise", cp_starve, i == STARVE - 1);
        end
        vu_val = 1'b0;
        cycle();
        chk("starve_fire", obs_fire, 1'b1);
        chk("starve_drop", cp_starve, 1'b0);
        drain();

        // Reset mid-flight: one result parked in the FIFO, three vector ops in the pipe.
        cp.cp_val = 1'b1;
        cycle();
        cp.cp_val = 1'b0;
        for (int i = 0; i < LAT; i++) cycle();
        vu_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_operands();
            cycle();
        end
        chk("pre_reset_resp_val", cp.cp_resp_val, 1'b1);
        vu_val = 1'b0;
        cp.cp_val = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_resp_val", cp.cp_resp_val, 1'b0);
        chk("rst_wb_val", wb_val, 1'b0);
        chk("rst_starve", cp_starve, 1'b0);
        chk("rst_fu_val", fu_val, 1'b0);
        chk("rst_cp_rdy", cp.cp_rdy, 1'b1);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cp.cp_resp_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            cycle();
            if (wb_val || cp.cp_resp_val) cnt++;
        end
        chk("post_reset_stale", cnt, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            vu_val         = ($urandom_range(0, 99) < 40);
            cp.cp_val      = ($urandom_range(0, 99) < 60);
            cp.cp_resp_rdy = ($urandom_range(0, 99) < 50);
            rand_operands();
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
